// File: rtl/fold_frame_sequencer_if.sv
// Sample-in / result-out stream bundle of the fold frame sequencer.
// The slave modport is the sequencer side; the master modport is its environment.
interface fold_frame_sequencer_if #(
    parameter int RES = 16
);
    logic [RES-1:0] s_data;
    logic           s_valid;
    logic           s_ready;
    logic [RES-1:0] m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/fold_frame_sequencer.sv
// Frame sequencer for the fold-removal engine: fills ROWS+EXTRA-sample frames, pulses the
// engine, drains ROWS results. Optional idle-fill timeout flush under FOLD_SEQ_TIMEOUT_EN.
module fold_frame_sequencer #(
    parameter int ROWS        = 32,
    parameter int EXTRA       = 2,
    parameter int RES         = 16,
    parameter int PROC_CYCLES = 34
`ifdef FOLD_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 1024
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    fold_frame_sequencer_if.slave       io,
    output logic [(ROWS+EXTRA)*RES-1:0] eng_frame,
    output logic                        eng_start,
    input  logic [ROWS*RES-1:0]         eng_result,
    output logic                        busy,
    output logic [15:0]                 frame_count,
    output logic                        timeout_flag
);
    localparam int SLOTS = ROWS + EXTRA;
    localparam int CW    = $clog2(SLOTS + 1);
    localparam int IW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WW    = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;

    typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_e;
    typedef logic [RES-1:0] sample_t;

    state_e        state_q, state_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [15:0]   frame_count_q, frame_count_d;
    sample_t       frame_q [SLOTS];
    sample_t       frame_d [SLOTS];
    sample_t       res_q [ROWS];
    sample_t       res_d [ROWS];
    sample_t       res_sel;
    logic          accept;
    logic          last_out;

`ifdef FOLD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          carry_q, carry_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] carry_cnt;
    sample_t       last_sample;
`endif

    assign accept   = io.s_valid && (state_q == FILL);
    assign last_out = (idx_q == IW'(ROWS - 1));

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        fill_cnt_d    = fill_cnt_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        frame_count_d = frame_count_q;
        frame_d       = frame_q;
        res_d         = res_q;

        res_sel = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (idx_q == IW'(k)) res_sel = res_q[k];
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < SLOTS; k++) begin
                        if (fill_cnt_q == CW'(k)) frame_d[k] = io.s_data;
                    end
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == CW'(SLOTS - 1)) state_d = START;
                end
            end
            START: begin
                wait_d  = WW'(PROC_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    for (int k = 0; k < ROWS; k++) res_d[k] = eng_result[k*RES +: RES];
                    state_d = DRAIN;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            DRAIN: begin
                if (io.m_ready) begin
                    if (last_out) begin
                        // Look-ahead tail becomes the head of the next frame.
                        for (int k = 0; k < EXTRA; k++) frame_d[k] = frame_q[ROWS + k];
                        fill_cnt_d    = CW'(EXTRA);
                        idx_d         = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = FILL;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

`ifdef FOLD_SEQ_TIMEOUT_EN
        carry_cnt   = carry_q ? CW'(EXTRA) : '0;
        last_sample = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (fill_cnt_q == CW'(k + 1)) last_sample = frame_q[k];
        end
        idle_d    = '0;
        carry_d   = carry_q;
        timeout_d = timeout_q;
        if (state_q == DRAIN && io.m_ready && last_out) carry_d = 1'b1;
        // Only frames holding at least one fresh sample can time out.
        if (state_q == FILL && !accept && fill_cnt_q > carry_cnt) begin
            if (idle_q == TW'(TIMEOUT - 1)) begin
                for (int k = 0; k < SLOTS; k++) begin
                    if (CW'(k) >= fill_cnt_q) frame_d[k] = last_sample;
                end
                fill_cnt_d = CW'(SLOTS);
                timeout_d  = 1'b1;
                state_d    = START;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
    end

    // NOTE: the frame and result buffers are cleared on reset because eng_frame is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            fill_cnt_q    <= '0;
            idx_q         <= '0;
            wait_q        <= '0;
            frame_count_q <= '0;
            for (int k = 0; k < SLOTS; k++) frame_q[k] <= '0;
            for (int k = 0; k < ROWS; k++)  res_q[k]   <= '0;
        end else begin
            state_q       <= state_d;
            fill_cnt_q    <= fill_cnt_d;
            idx_q         <= idx_d;
            wait_q        <= wait_d;
            frame_count_q <= frame_count_d;
            frame_q       <= frame_d;
            res_q         <= res_d;
        end
    end

`ifdef FOLD_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q    <= '0;
            carry_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            carry_q   <= carry_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    for (genvar k = 0; k < SLOTS; k++) begin : g_frame
        assign eng_frame[k*RES +: RES] = frame_q[k];
    end

    assign io.s_ready  = (state_q == FILL);
    assign io.m_valid  = (state_q == DRAIN);
    assign io.m_last   = (state_q == DRAIN) && last_out;
    assign io.m_data   = (state_q == DRAIN) ? res_sel : '0;
    assign eng_start   = (state_q == START);
    assign busy        = (state_q != FILL);
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_fold_frame_sequencer.sv
// Directed bench for fold_frame_sequencer (ROWS=4, EXTRA=2, PROC_CYCLES=3); the
// timeout scenario follows FOLD_SEQ_TIMEOUT_EN with TIMEOUT=8.
module tb_fold_frame_sequencer;
    localparam int ROWS        = 4;
    localparam int EXTRA       = 2;
    localparam int RES         = 16;
    localparam int PROC_CYCLES = 3;
    localparam int SLOTS       = ROWS + EXTRA;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [SLOTS*RES-1:0]   eng_frame;
    logic                   eng_start;
    logic [ROWS*RES-1:0]    eng_result;
    logic                   busy;
    logic [15:0]            frame_count;
    logic                   timeout_flag;
    int                     checks = 0;
    int                     errors = 0;

    fold_frame_sequencer_if #(.RES(RES)) io ();

    fold_frame_sequencer #(
        .ROWS(ROWS),
        .EXTRA(EXTRA),
        .RES(RES),
        .PROC_CYCLES(PROC_CYCLES)
`ifdef FOLD_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(io),
        .eng_frame(eng_frame),
        .eng_start(eng_start),
        .eng_result(eng_result),
        .busy(busy),
        .frame_count(frame_count),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SLOTS*RES-1:0] pack6(input int v0, input int v1, input int v2,
                                                    input int v3, input int v4, input int v5);
        logic [SLOTS*RES-1:0] v;
        v = {16'(v5), 16'(v4), 16'(v3), 16'(v2), 16'(v1), 16'(v0)};
        return v;
    endfunction

    task automatic set_result(input int base);
        for (int k = 0; k < ROWS; k++) eng_result[k*RES +: RES] = 16'(base + k);
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        io.s_valid   = 1'b0;
        io.s_data    = '0;
        io.m_ready   = 1'b0;
        eng_result   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Streams n consecutive values starting at first, one per cycle.
    task automatic feed(input int first, input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            io.s_valid = 1'b1;
            io.s_data  = 16'(first + i);
            checks++;
            if (io.s_ready !== 1'b1 || eng_start !== 1'b0) begin
                errors++;
                $display("FAIL feed_%0d: s_ready=%b eng_start=%b, required s_ready=1 eng_start=0",
                         first + i, io.s_ready, eng_start);
            end
            tick();
        end
        io.s_valid = hold;
        io.s_data  = 16'(first + n);
    endtask

    task automatic wait_first_valid(input string tag);
        int lat  = 0;
        bit seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            checks++;
            if (eng_start !== 1'b0 || io.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_cycle%0d: eng_start=%b s_ready=%b, required 0 0",
                         tag, c, eng_start, io.s_ready);
            end
            if (io.m_valid === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        checks++;
        if (lat != PROC_CYCLES + 1) begin
            errors++;
            $display("FAIL %s_latency: start to m_valid %0d cycles (0 = never), required %0d",
                     tag, lat, PROC_CYCLES + 1);
        end
    endtask

    task automatic drain(input string tag, input int base, input int stall_idx, input int stall_len);
        io.m_ready = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            if (i == stall_idx) begin
                io.m_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    checks++;
                    if (io.m_valid !== 1'b1 || io.m_data !== 16'(base + i) || io.s_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_stall%0d: m_valid=%b m_data=%0d s_ready=%b, required 1 %0d 0",
                                 tag, s, io.m_valid, io.m_data, io.s_ready, base + i);
                    end
                end
                io.m_ready = 1'b1;
            end
            checks++;
            if (io.m_valid !== 1'b1 || io.m_data !== 16'(base + i) ||
                io.m_last !== (i == ROWS - 1) || io.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_out%0d: m_valid=%b m_data=%0d m_last=%b s_ready=%b, required 1 %0d %b 0",
                         tag, i, io.m_valid, io.m_data, io.m_last, io.s_ready, base + i, (i == ROWS - 1));
            end
            tick();
        end
        io.m_ready = 1'b0;
        checks++;
        if (io.m_valid !== 1'b0 || io.s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_exit: m_valid=%b s_ready=%b busy=%b, required 0 1 0",
                     tag, io.m_valid, io.s_ready, busy);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (io.s_ready !== 1'b1 || io.m_valid !== 1'b0 || io.m_last !== 1'b0 || io.m_data !== '0) begin
            errors++;
            $display("FAIL reset_stream: s_ready=%b m_valid=%b m_last=%b m_data=%0d, required 1 0 0 0",
                     io.s_ready, io.m_valid, io.m_last, io.m_data);
        end
        checks++;
        if (eng_start !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: eng_start=%b busy=%b frame_count=%0d timeout_flag=%b, required 0 0 0 0",
                     eng_start, busy, frame_count, timeout_flag);
        end
        checks++;
        if (eng_frame !== '0) begin
            errors++;
            $display("FAIL reset_frame: eng_frame=%h, required 0", eng_frame);
        end
    endtask

    task automatic test_first_frame();
        feed(1, 6, 1'b0);
        checks++;
        if (eng_start !== 1'b1 || io.s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start: eng_start=%b s_ready=%b busy=%b, required 1 0 1",
                     eng_start, io.s_ready, busy);
        end
        checks++;
        if (eng_frame !== pack6(1, 2, 3, 4, 5, 6)) begin
            errors++;
            $display("FAIL first_frame: eng_frame=%h, required %h", eng_frame, pack6(1, 2, 3, 4, 5, 6));
        end
        set_result(100);
        wait_first_valid("first");
        drain("first", 100, -1, 0);
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL first_count: frame_count=%0d, required 1", frame_count);
        end
    endtask

    // Overlapped frame, mid-drain stall, and s_valid held high while busy.
    task automatic test_overlap_stall();
        feed(7, 4, 1'b1);
        checks++;
        if (eng_start !== 1'b1 || eng_frame !== pack6(5, 6, 7, 8, 9, 10)) begin
            errors++;
            $display("FAIL overlap_frame: eng_start=%b eng_frame=%h, required 1 %h",
                     eng_start, eng_frame, pack6(5, 6, 7, 8, 9, 10));
        end
        set_result(200);
        wait_first_valid("second");
        drain("second", 200, 1, 5);
        checks++;
        if (frame_count !== 16'd2) begin
            errors++;
            $display("FAIL second_count: frame_count=%0d, required 2", frame_count);
        end
    endtask

    task automatic test_reset_in_wait();
        feed(11, 4, 1'b0);
        checks++;
        if (eng_start !== 1'b1 || eng_frame !== pack6(9, 10, 11, 12, 13, 14)) begin
            errors++;
            $display("FAIL busy_hold_frame: eng_start=%b eng_frame=%h, required 1 %h",
                     eng_start, eng_frame, pack6(9, 10, 11, 12, 13, 14));
        end
        set_result(300);
        tick();
        checks++;
        if (busy !== 1'b1 || eng_start !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: busy=%b eng_start=%b, required 1 0", busy, eng_start);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (eng_start !== 1'b0 || io.m_valid !== 1'b0 || busy !== 1'b0 ||
            frame_count !== 16'd0 || eng_frame !== '0 || io.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_reset: eng_start=%b m_valid=%b busy=%b frame_count=%0d eng_frame=%h s_ready=%b, required 0 0 0 0 0 1",
                     eng_start, io.m_valid, busy, frame_count, eng_frame, io.s_ready);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (eng_start !== 1'b0 || io.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle%0d: eng_start=%b m_valid=%b, required 0 0",
                         c, eng_start, io.m_valid);
            end
        end
        feed(21, 6, 1'b0);
        checks++;
        if (eng_start !== 1'b1 || eng_frame !== pack6(21, 22, 23, 24, 25, 26)) begin
            errors++;
            $display("FAIL fresh_frame: eng_start=%b eng_frame=%h, required 1 %h",
                     eng_start, eng_frame, pack6(21, 22, 23, 24, 25, 26));
        end
        set_result(400);
        wait_first_valid("fresh");
        drain("fresh", 400, -1, 0);
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL fresh_count: frame_count=%0d, required 1", frame_count);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        feed(31, 3, 1'b0);
`ifdef FOLD_SEQ_TIMEOUT_EN
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (eng_start !== 1'b0 || timeout_flag !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early%0d: eng_start=%b timeout_flag=%b, required 0 0",
                         c, eng_start, timeout_flag);
            end
        end
        tick();
        checks++;
        if (eng_start !== 1'b1 || timeout_flag !== 1'b1 || eng_frame !== pack6(31, 32, 33, 33, 33, 33)) begin
            errors++;
            $display("FAIL timeout_flush: eng_start=%b timeout_flag=%b eng_frame=%h, required 1 1 %h",
                     eng_start, timeout_flag, eng_frame, pack6(31, 32, 33, 33, 33, 33));
        end
        set_result(500);
        wait_first_valid("timeout");
        drain("timeout", 500, -1, 0);
        // Only carry samples are held now, so no further flush may happen.
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (eng_start !== 1'b0 || timeout_flag !== 1'b1) begin
                errors++;
                $display("FAIL carry_idle%0d: eng_start=%b timeout_flag=%b, required 0 1",
                         c, eng_start, timeout_flag);
            end
        end
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (eng_start !== 1'b0 || timeout_flag !== 1'b0 || io.s_ready !== 1'b1) begin
                errors++;
                $display("FAIL no_timeout%0d: eng_start=%b timeout_flag=%b s_ready=%b, required 0 0 1",
                         c, eng_start, timeout_flag, io.s_ready);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_overlap_stall();
        test_reset_in_wait();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required the test sequence to end");
        $fatal(1, "watchdog expired");
    end
endmodule
